// File: rtl/syscall_unit_if.sv
// syscall_unit bus bundle: data-memory read port and console stream.
// master = syscall unit, slave = memory/console side.
interface syscall_unit_if;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  modport master (
    output mem_rd, mem_addr,
    input  mem_rdata, mem_ready,
    output out_valid, out_data,
    input  out_ready
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_rdata, mem_ready,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

// File: rtl/syscall_unit.sv
// MIPS syscall service unit: print_int/string/char, exit.
// Define SYSCALL_HEX_EN to add print_int_hex (code 34).
module syscall_unit #(
  parameter int MAX_STR_LEN = 1024,
  parameter int CNT_W       = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall,
  input  logic [31:0] sys_call_reg,
  input  logic [31:0] std_out_address,
  output logic        stall,
  output logic        halted,
  output logic        err,
  syscall_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DISPATCH,
    S_INT_SIGN,
    S_INT_DIGIT,
    S_STR_REQ,
    S_STR_BYTE,
    S_EMIT,
    S_HEX_PFX,
    S_HEX_DIGIT,
    S_HALTED
  } state_t;

  state_t state, state_d;

  logic [31:0]      code, code_d;
  logic [31:0]      arg, arg_d;
  logic [31:0]      mag, mag_d;
  logic [3:0]       k, k_d;
  logic [3:0]       digit, digit_d;
  logic             printed, printed_d;
  logic [31:0]      ptr, ptr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      word, word_d;
  logic             err_q, err_d;
  logic             ov_q;
  logic [7:0]       od_q;

  logic             emit;
  logic [7:0]       emit_ch;
  logic             can_emit;
  logic [31:0]      pow_k;
  logic [7:0]       str_byte;
  logic [3:0]       nib;
  logic [7:0]       hex_ch;

  function automatic logic [31:0] pow10(
    input logic [3:0] e
  );
    case (e)
      4'd0:    return 32'd1;
      4'd1:    return 32'd10;
      4'd2:    return 32'd100;
      4'd3:    return 32'd1000;
      4'd4:    return 32'd10000;
      4'd5:    return 32'd100000;
      4'd6:    return 32'd1000000;
      4'd7:    return 32'd10000000;
      4'd8:    return 32'd100000000;
      4'd9:    return 32'd1000000000;
      default: return 32'd1;
    endcase
  endfunction

  assign pow_k   = pow10(k);
  assign cnt_inc = cnt + CNT_W'(1);
  assign nib     = mag[31:28];
  assign hex_ch  = (nib < 4'd10)
                 ? 8'h30 + {4'h0, nib}
                 : 8'h57 + {4'h0, nib};

  always_comb begin
    str_byte = word[31:24];
    unique case (ptr[1:0])
      2'd0: str_byte = word[31:24];
      2'd1: str_byte = word[23:16];
      2'd2: str_byte = word[15:8];
      2'd3: str_byte = word[7:0];
    endcase
  end

  // One-entry output buffer: a new char may load while the old one drains.
  assign can_emit = !ov_q || bus.out_ready;

  assign stall = (syscall && state == S_IDLE)
              || (state != S_IDLE && state != S_HALTED);

  assign halted = (state == S_HALTED);
  assign err    = err_q;

  assign bus.mem_rd    = (state == S_STR_REQ);
  assign bus.mem_addr  = (state == S_STR_REQ)
                       ? {ptr[31:2], 2'b00} : 32'h0;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;

  always_comb begin
    state_d   = state;
    code_d    = code;
    arg_d     = arg;
    mag_d     = mag;
    k_d       = k;
    digit_d   = digit;
    printed_d = printed;
    ptr_d     = ptr;
    cnt_d     = cnt;
    word_d    = word;
    err_d     = 1'b0;
    emit      = 1'b0;
    emit_ch   = 8'h00;

    case (state)
      S_IDLE: begin
        if (syscall) begin
          code_d  = sys_call_reg;
          arg_d   = std_out_address;
          state_d = S_DISPATCH;
        end
      end

      S_DISPATCH: begin
        ptr_d     = arg;
        cnt_d     = '0;
        printed_d = 1'b0;
        digit_d   = 4'd0;
        k_d       = 4'd0;
        unique case (1'b1)
          (code == 32'd1):  state_d = S_INT_SIGN;
          (code == 32'd4):  state_d = S_STR_REQ;
          (code == 32'd10): state_d = S_HALTED;
          (code == 32'd11): state_d = S_EMIT;
`ifdef SYSCALL_HEX_EN
          (code == 32'd34): state_d = S_HEX_PFX;
`endif
          default: begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end

      S_INT_SIGN: begin
        if (!arg[31]) begin
          mag_d   = arg;
          k_d     = 4'd9;
          state_d = S_INT_DIGIT;
        end else if (can_emit) begin
          emit    = 1'b1;
          emit_ch = 8'h2d;
          mag_d   = 32'd0 - arg;
          k_d     = 4'd9;
          state_d = S_INT_DIGIT;
        end
      end

      S_INT_DIGIT: begin
        if (mag >= pow_k) begin
          mag_d   = mag - pow_k;
          digit_d = digit + 4'd1;
        end else if (digit != 4'd0 || printed
                     || k == 4'd0) begin
          if (can_emit) begin
            emit      = 1'b1;
            emit_ch   = 8'h30 + {4'h0, digit};
            printed_d = 1'b1;
            digit_d   = 4'd0;
            k_d       = k - 4'd1;
            if (k == 4'd0) state_d = S_IDLE;
          end
        end else begin
          digit_d = 4'd0;
          k_d     = k - 4'd1;
        end
      end

      S_STR_REQ: begin
        if (bus.mem_ready) begin
          word_d  = bus.mem_rdata;
          state_d = S_STR_BYTE;
        end
      end

      S_STR_BYTE: begin
        if (str_byte == 8'h00) begin
          state_d = S_IDLE;
        end else if (can_emit) begin
          emit    = 1'b1;
          emit_ch = str_byte;
          ptr_d   = ptr + 32'd1;
          cnt_d   = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_STR_LEN)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (ptr_d[1:0] == 2'b00) begin
            state_d = S_STR_REQ;
          end
        end
      end

      S_EMIT: begin
        if (can_emit) begin
          emit    = 1'b1;
          emit_ch = arg[7:0];
          state_d = S_IDLE;
        end
      end

      // k counts prefix chars here, then hex digits below.
      S_HEX_PFX: begin
        if (can_emit) begin
          emit = 1'b1;
          if (k == 4'd0) begin
            emit_ch = 8'h30;
            k_d     = 4'd1;
          end else begin
            emit_ch = 8'h78;
            k_d     = 4'd0;
            mag_d   = arg;
            state_d = S_HEX_DIGIT;
          end
        end
      end

      S_HEX_DIGIT: begin
        if (can_emit) begin
          emit    = 1'b1;
          emit_ch = hex_ch;
          mag_d   = {mag[27:0], 4'h0};
          k_d     = k + 4'd1;
          if (k == 4'd7) state_d = S_IDLE;
        end
      end

      S_HALTED: state_d = S_HALTED;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code    <= 32'h0;
      arg     <= 32'h0;
      mag     <= 32'h0;
      k       <= 4'd0;
      digit   <= 4'd0;
      printed <= 1'b0;
      ptr     <= 32'h0;
      cnt     <= '0;
      word    <= 32'h0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= 8'h00;
    end else begin
      code    <= code_d;
      arg     <= arg_d;
      mag     <= mag_d;
      k       <= k_d;
      digit   <= digit_d;
      printed <= printed_d;
      ptr     <= ptr_d;
      cnt     <= cnt_d;
      word    <= word_d;
      err_q   <= err_d;
      if (emit) begin
        ov_q <= 1'b1;
        od_q <= emit_ch;
      end else if (bus.out_ready) begin
        ov_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit with memory model
// and console sink; characters packed into a 128-bit word.
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        syscall = 1'b0;
  logic [31:0] sys_call_reg = 32'h0;
  logic [31:0] std_out_address = 32'h0;
  logic        stall;
  logic        halted;
  logic        err;

  syscall_unit_if bus ();

  syscall_unit u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .syscall         (syscall),
    .sys_call_reg    (sys_call_reg),
    .std_out_address (std_out_address),
    .stall           (stall),
    .halted          (halted),
    .err             (err),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] got_str;
  int           n_chars;
  int           n_reads;
  int           n_err;
  int           hold_viol = 0;
  logic [31:0]  rd_addr [4];
  logic         pend = 1'b0;
  logic [7:0]   pend_data;
  logic         ready_level = 1'b1;
  logic         toggle_en = 1'b0;
  logic         stall_at_call;
  logic         timed_out;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    case (a)
      32'h100: return 32'h00004869;
      32'h104: return 32'h21000000;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    bus.mem_ready <= bus.mem_rd && !bus.mem_ready;
    bus.mem_rdata <= mem_word(bus.mem_addr);
  end

  always @(negedge clk) begin
    if (toggle_en) bus.out_ready = ~bus.out_ready;
    else           bus.out_ready = ready_level;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        got_str = {got_str[119:0], bus.out_data};
        n_chars++;
      end
      if (bus.mem_rd && bus.mem_ready) begin
        if (n_reads < 4) rd_addr[n_reads] = bus.mem_addr;
        n_reads++;
      end
      if (err) n_err++;
      if (pend && (!bus.out_valid
                   || bus.out_data != pend_data))
        hold_viol++;
      pend      = bus.out_valid && !bus.out_ready;
      pend_data = bus.out_data;
    end else begin
      pend = 1'b0;
    end
  end

  task automatic clear();
    got_str = '0;
    n_chars = 0;
    n_reads = 0;
    n_err   = 0;
    for (int i = 0; i < 4; i++) rd_addr[i] = '0;
  endtask

  task automatic run(
    input logic [31:0] code,
    input logic [31:0] arg
  );
    clear();
    @(negedge clk);
    syscall         = 1'b1;
    sys_call_reg    = code;
    std_out_address = arg;
    #1 stall_at_call = stall;
    @(negedge clk);
    syscall = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!stall && !bus.out_valid) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("timeout", 128'(timed_out), 128'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_stall", 128'(stall), 128'd0);
    check("rst_bus", 128'({bus.mem_rd, bus.mem_addr,
          bus.out_valid, bus.out_data}), 128'd0);
    check("rst_halt_err", 128'({halted, err}), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(32'd1, 32'hFFFFFED1);
    check("neg303_stall_call", 128'(stall_at_call), 128'd1);
    check("neg303_str", got_str, "-303");
    check("neg303_stall_end", 128'(stall), 128'd0);

    run(32'd1, 32'd0);
    check("zero_str", got_str, "0");

    run(32'd1, 32'h80000000);
    check("min_str", got_str, "-2147483648");
    check("min_len", 128'(n_chars), 128'd11);

    run(32'd4, 32'h102);
    check("str_out", got_str, "Hi!");
    check("str_nreads", 128'(n_reads), 128'd2);
    check("str_addr0", 128'(rd_addr[0]), 128'h100);
    check("str_addr1", 128'(rd_addr[1]), 128'h104);

    toggle_en = 1'b1;
    run(32'd4, 32'h102);
    toggle_en = 1'b0;
    @(negedge clk);
    check("strtog_out", got_str, "Hi!");
    check("strtog_nreads", 128'(n_reads), 128'd2);

    run(32'd11, 32'h141);
    check("char_out", got_str, "A");

    run(32'd99, 32'd0);
    check("bad_err", 128'(n_err), 128'd1);
    check("bad_nchars", 128'(n_chars), 128'd0);

    run(32'd34, 32'd42);
`ifdef SYSCALL_HEX_EN
    check("hex_out", got_str, "0x0000002a");
    check("hex_err", 128'(n_err), 128'd0);
`else
    check("hex_err", 128'(n_err), 128'd1);
    check("hex_nchars", 128'(n_chars), 128'd0);
`endif

    clear();
    @(negedge clk);
    syscall         = 1'b1;
    sys_call_reg    = 32'd4;
    std_out_address = 32'h102;
    @(negedge clk);
    syscall = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (n_chars >= 1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("rstmid_timeout", 128'(timed_out), 128'd0);
    check("rstmid_first", got_str, "H");
    rst_n = 1'b0;
    #1;
    check("rstmid_outs", 128'({stall, bus.mem_rd,
          bus.mem_addr, bus.out_valid, bus.out_data,
          halted, err}), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear();
    repeat (20) @(negedge clk);
    check("rstmid_nchars", 128'(n_chars), 128'd0);
    check("rstmid_nreads", 128'(n_reads), 128'd0);

    run(32'd10, 32'd0);
    check("exit_halted", 128'(halted), 128'd1);
    check("exit_stall", 128'(stall), 128'd0);

    run(32'd11, 32'h141);
    check("halt_stall_call", 128'(stall_at_call), 128'd0);
    check("halt_nchars", 128'(n_chars), 128'd0);
    check("halt_sticky", 128'(halted), 128'd1);

    check("hold_viol", 128'(hold_viol), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
